// File: rtl/sha_padder_if.sv
// Byte-in / block-out stream bundle for the SHA message padder.
// The padder takes the slave side; the byte source and block sink take the master side.
interface sha_padder_if;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [511:0] blk_data;
   logic         blk_valid;
   logic         blk_last;
   logic         blk_ready;

   modport master (
      output in_data, in_valid, in_last, blk_ready,
      input  in_ready, blk_data, blk_valid, blk_last
   );

   modport slave (
      input  in_data, in_valid, in_last, blk_ready,
      output in_ready, blk_data, blk_valid, blk_last
   );
endinterface

// File: rtl/sha_padder.sv
// SHA-256 message padder: packs bytes into 512-bit blocks, then appends the
// 0x80 marker, zero fill and the 64-bit big-endian bit length.
module sha_padder (
   input logic        clk,
   input logic        rst_n,
   sha_padder_if.slave bus
);
   localparam logic [1:0] LOAD       = 2'd0;
   localparam logic [1:0] EMIT_DATA  = 2'd1;
   localparam logic [1:0] EMIT_PAD   = 2'd2;
   localparam logic [1:0] EMIT_FINAL = 2'd3;

   logic [1:0]   st, st_n;
   logic [5:0]   p, p_n;
   logic [60:0]  cnt, cnt_n;
   logic         pad80, pad80_n;
   logic         last_q, last_n;
   logic         vld_q;
   logic [511:0] blk_q, blk_n;
   logic [63:0]  len_ld;
   logic [6:0]   pp;
   logic [6:0]   idx;

   assign bus.in_ready  = rst_n & (st == LOAD);
   assign bus.blk_data  = blk_q;
   assign bus.blk_valid = vld_q;
   assign bus.blk_last  = last_q;

   // Bit length including the byte being accepted this cycle.
   assign len_ld = {cnt + 61'd1, 3'b000};
   assign pp     = {1'b0, p};

   always_comb begin
      st_n    = st;
      p_n     = p;
      cnt_n   = cnt;
      pad80_n = pad80;
      last_n  = last_q;
      blk_n   = blk_q;
      idx     = '0;
      case (st)
         LOAD: begin
            if (bus.in_valid) begin
               p_n   = p + 6'd1;
               cnt_n = cnt + 61'd1;
               for (int i = 0; i < 64; i++) begin
                  idx = 7'(i);
                  if (idx == pp) begin
                     blk_n[511-8*i -: 8] = bus.in_data;
                  end else if (bus.in_last && idx > pp) begin
                     if (idx == pp + 7'd1)
                        blk_n[511-8*i -: 8] = 8'h80;
                     else if (idx >= 7'd56 && p <= 6'd54)
                        blk_n[511-8*i -: 8] = len_ld[8*(63-i) +: 8];
                     else
                        blk_n[511-8*i -: 8] = 8'h00;
                  end
               end
               if (bus.in_last) begin
                  if (p <= 6'd54) begin
                     st_n   = EMIT_FINAL;
                     last_n = 1'b1;
                  end else begin
                     st_n    = EMIT_PAD;
                     last_n  = 1'b0;
                     pad80_n = (p == 6'd63);
                  end
               end else if (p == 6'd63) begin
                  st_n   = EMIT_DATA;
                  last_n = 1'b0;
               end
            end
         end
         EMIT_DATA: begin
            if (bus.blk_ready) begin
               blk_n = '0;
               st_n  = LOAD;
            end
         end
         EMIT_PAD: begin
            if (bus.blk_ready) begin
               blk_n            = '0;
               blk_n[511:504]   = pad80 ? 8'h80 : 8'h00;
               blk_n[63:0]      = {cnt, 3'b000};
               st_n             = EMIT_FINAL;
               last_n           = 1'b1;
            end
         end
         default: begin
            if (bus.blk_ready) begin
               blk_n   = '0;
               p_n     = '0;
               cnt_n   = '0;
               pad80_n = 1'b0;
               last_n  = 1'b0;
               st_n    = LOAD;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st     <= LOAD;
         p      <= '0;
         cnt    <= '0;
         pad80  <= 1'b0;
         last_q <= 1'b0;
         vld_q  <= 1'b0;
         blk_q  <= '0;
      end else begin
         st     <= st_n;
         p      <= p_n;
         cnt    <= cnt_n;
         pad80  <= pad80_n;
         last_q <= last_n;
         vld_q  <= (st_n != LOAD);
         blk_q  <= blk_n;
      end
   end
endmodule

// File: tb/tb_sha_padder.sv
// Directed bench for sha_padder: known padding vectors, backpressure,
// and reset in the middle of a message.
module tb_sha_padder;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   logic [511:0] q_data[$];
   logic         q_last[$];

   sha_padder_if bus ();

   sha_padder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && bus.blk_valid && bus.blk_ready) begin
         q_data.push_back(bus.blk_data);
         q_last.push_back(bus.blk_last);
      end
   end

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      bus.in_last  = l;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) chk("in_ready_timeout", 512'(0), 512'(1));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send_fill(input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++) send_byte(d, i == n - 1);
   endtask

   task automatic send_abc();
      send_byte(8'h61, 1'b0);
      send_byte(8'h62, 1'b0);
      send_byte(8'h63, 1'b1);
   endtask

   task automatic wait_blocks(input string tag, input int n);
      int k;
      k = 0;
      while (q_data.size() < n && k < 300) begin
         @(negedge clk);
         k++;
      end
      repeat (5) @(negedge clk);
      chk(tag, 512'(q_data.size()), 512'(n));
      @(posedge clk);
      #1;
   endtask

   task automatic expect_blk(input string tag, input logic [511:0] d,
                             input logic l);
      if (q_data.size() == 0) begin
         chk({tag, "_missing"}, 512'(0), 512'(1));
      end else begin
         chk({tag, "_data"}, q_data.pop_front(), d);
         chk({tag, "_last"}, 512'(q_last.pop_front()), 512'(l));
      end
   endtask

   localparam logic [511:0] ABC_BLK = {32'h61626380, 416'd0, 64'h18};
   localparam logic [511:0] Z55_BLK = {440'd0, 8'h80, 64'h1B8};
   localparam logic [511:0] Z56_B1  = {448'd0, 8'h80, 56'd0};
   localparam logic [511:0] Z56_B2  = {448'd0, 64'h1C0};
   localparam logic [511:0] FF_B1   = {512{1'b1}};
   localparam logic [511:0] F64_B2  = {8'h80, 440'd0, 64'h200};
   localparam logic [511:0] F65_B2  = {8'hFF, 8'h80, 432'd0, 64'h208};

   initial begin
      n_chk        = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.blk_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 512'(bus.in_ready), 512'(0));
      chk("rst_blk_valid", 512'(bus.blk_valid), 512'(0));
      chk("rst_blk_last", 512'(bus.blk_last), 512'(0));
      chk("rst_blk_data", bus.blk_data, 512'(0));
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 512'(bus.in_ready), 512'(1));
      @(posedge clk);
      #1;

      send_abc();
      wait_blocks("abc_count", 1);
      expect_blk("abc", ABC_BLK, 1'b1);

      send_fill(8'h00, 55);
      wait_blocks("z55_count", 1);
      expect_blk("z55", Z55_BLK, 1'b1);

      send_fill(8'h00, 56);
      wait_blocks("z56_count", 2);
      expect_blk("z56_b1", Z56_B1, 1'b0);
      expect_blk("z56_b2", Z56_B2, 1'b1);

      send_fill(8'hFF, 64);
      wait_blocks("f64_count", 2);
      expect_blk("f64_b1", FF_B1, 1'b0);
      expect_blk("f64_b2", F64_B2, 1'b1);

      send_fill(8'hFF, 65);
      wait_blocks("f65_count", 2);
      expect_blk("f65_b1", FF_B1, 1'b0);
      expect_blk("f65_b2", F65_B2, 1'b1);

      bus.blk_ready = 1'b0;
      send_abc();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_valid", 512'(bus.blk_valid), 512'(1));
         chk("bp_data", bus.blk_data, ABC_BLK);
         chk("bp_in_ready", 512'(bus.in_ready), 512'(0));
      end
      @(posedge clk);
      #1;
      bus.blk_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_ready_after", 512'(bus.in_ready), 512'(1));
      chk("bp_valid_after", 512'(bus.blk_valid), 512'(0));
      wait_blocks("bp_count", 1);
      expect_blk("bp", ABC_BLK, 1'b1);

      for (int i = 0; i < 30; i++) send_byte(8'h5A, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_in_ready", 512'(bus.in_ready), 512'(0));
      chk("mid_rst_valid", 512'(bus.blk_valid), 512'(0));
      repeat (3) @(negedge clk);
      chk("mid_rst_valid_hold", 512'(bus.blk_valid), 512'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_abc();
      wait_blocks("after_rst_count", 1);
      expect_blk("after_rst", ABC_BLK, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
